uart_mem_loader: RTL

Serial-to-memory loader for the filter platform. It receives a length-prefixed byte stream on the board UART RX pin, assembles little-endian 32-bit words and writes them to consecutive word addresses of the RISC-V data memory starting at word 0. It provides the input path for image data and filter parameters, the counterpart to the seven-segment readout path. It contains an 8N1 UART receiver and a framing FSM, and reports progress on `busy`, `done` and `err`.

---
 rtl/uart_mem_loader_pkg.sv | 24 ++
 rtl/uart_mem_loader_if.sv | 12 +
 rtl/uart_mem_loader_rx.sv | 97 +++++++++
 rtl/uart_mem_loader.sv | 128 ++++++++++++
 4 files changed

// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART memory loader: state encodings of the
// receiver and the framing FSM, plus the default baud divisor.
package uart_pkg;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_HI,
    LD_DATA,
    LD_DONE,
    LD_ERR
  } ld_state_t;

endpackage

// File: rtl/uart_mem_loader_if.sv
// Word-write bus from the loader into the data memory. The loader drives
// it; the memory only listens, since there is no back-pressure.
interface uart_mem_loader_if #(
  parameter int ADDR_W = 15
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_mem_loader_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling driven by a
// baud counter, one-cycle pulses for a good byte or a bad stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  logic             rx_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  // Bring the asynchronous line into the clock domain; idle level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Start detection, mid-bit sampling of data and stop bit, re-arm on idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (state)
        RX_IDLE: begin
          baud_cnt <= '0;
          if (!rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= shift_reg;
            end else begin
              rx_ferr <= 1'b1;
            end
            state <= RX_WAIT_HIGH;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Length-prefixed serial loader: LEN_LO, LEN_HI, then LEN little-endian
// 32-bit words written to consecutive data-memory words starting at 0.
module uart_mem_loader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int MEMSIZE      = 2**15,
  parameter int ADDR_W       = $clog2(MEMSIZE)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  uart_mem_loader_if.master mem,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written
);

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_ferr;

  ld_state_t         state;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [15:0]       len_next;
  logic [1:0]        byte_idx;
  logic [23:0]       word_reg;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  assign len_next      = {rx_byte, len_lo};
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  // Framing FSM: length capture, word assembly, registered memory writes
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LD_IDLE;
      len_lo        <= '0;
      len           <= '0;
      byte_idx      <= '0;
      word_reg      <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (rx_ferr && state != LD_ERR) begin
        state <= LD_ERR;
        busy  <= 1'b0;
        err   <= 1'b1;
      end else begin
        case (state)
          LD_IDLE, LD_DONE: begin
            if (rx_valid) begin
              len_lo        <= rx_byte;
              done          <= 1'b0;
              words_written <= '0;
              busy          <= 1'b1;
              state         <= LD_LEN_HI;
            end
          end
          LD_LEN_HI: begin
            if (rx_valid) begin
              len      <= len_next;
              byte_idx <= '0;
              if (len_next == 16'd0) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= LD_DONE;
              end else if (32'(len_next) > MEMSIZE) begin
                busy  <= 1'b0;
                err   <= 1'b1;
                state <= LD_ERR;
              end else begin
                state <= LD_DATA;
              end
            end
          end
          LD_DATA: begin
            if (rx_valid) begin
              byte_idx <= byte_idx + 1'b1;
              case (byte_idx)
                2'd0: word_reg[7:0]   <= rx_byte;
                2'd1: word_reg[15:8]  <= rx_byte;
                2'd2: word_reg[23:16] <= rx_byte;
                default: begin
                  mem_we_q      <= 1'b1;
                  mem_addr_q    <= words_written[ADDR_W-1:0];
                  mem_wdata_q   <= {rx_byte, word_reg};
                  words_written <= words_written + 16'd1;
                  if (words_written + 16'd1 == len) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= LD_DONE;
                  end
                end
              endcase
            end
          end
          LD_ERR: begin
            busy <= 1'b0;
            err  <= 1'b1;
          end
          default: state <= LD_IDLE;
        endcase
      end
    end
  end

endmodule
